seq_neural_net: RTL
===================

Name: seq_neural_net

Overview:
- Time-multiplexed, parametrised fully-connected network engine: LAYERS layers of N neurons, each with N inputs, using one shared multiply-accumulate unit.
- Replaces the fixed 2x2x2 combinational network with a sequential engine that has these additions:
  - writable coefficient/bias memory;
  - valid/ready streaming handshakes;
  - selectable activation;
  - saturating fixed-point arithmetic.
- Sits between the input sample source and the classifier/readout logic.

Parameters:
- WIDTH, 16: data, coefficient and bias width; signed fixed point.
- FRAC, 8: fractional bits (Q(WIDTH-FRAC).FRAC).
- N, 2: neurons per layer, which is also the number of inputs per neuron; N >= 1.
- LAYERS, 2: number of layers; LAYERS >= 1.
- ACT, 0: activation applied after each layer. 0 = identity; 1 = ReLU.
- Derived, ADDR_W = clog2(LAYERS*N*(N+1)): coefficient address width.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: input vector valid.
- in_ready, output, 1: engine can accept a vector.
- in_data, input, N*WIDTH: input vector; element i is at bits [i*WIDTH +: WIDTH].
- out_valid, output, 1: result vector valid.
- out_ready, input, 1: downstream accepts the result.
- out_data, output, N*WIDTH: result vector, same packing as in_data.
- cfg_we, input, 1: coefficient write strobe.
- cfg_addr, input, ADDR_W: coefficient address.
- cfg_data, input, WIDTH: coefficient value.
- busy, output, 1: high whenever the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - in_ready=0, out_valid=0, out_data=0, busy=0.
  - FSM enters IDLE; accumulator, vector buffers and all coefficient registers clear to 0.
  - in_ready rises on the first clock after reset release.
- Coefficient map:
  - Weight for (layer l, neuron j, source i) is at address (l*N+j)*N+i.
  - Bias for (l, j) is at address LAYERS*N*N + l*N + j.
  - Addresses >= LAYERS*N*(N+1) are ignored.
- Coefficient writes:
  - A write takes effect on the clock edge where cfg_we=1 and busy=0.
  - cfg_we while busy=1 is dropped silently.
- FSM states: IDLE, MAC, BIAS, OUT.
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_data into the source buffer, set l=j=i=0, clear the accumulator, go to MAC.
  - MAC: one product per cycle, acc += src[i]*w(l,j,i). After i=N-1, go to BIAS.
  - BIAS (1 cycle):
    - Compute r = sat(activation((acc >>> FRAC) + bias(l,j))) and write r to dest[j]; clear acc.
    - If j<N-1: j++, go to MAC.
    - Else if l<LAYERS-1: copy dest to src, l++, j=0, go to MAC.
    - Else: drive out_data=dest, go to OUT.
  - OUT: out_valid=1. out_data is held stable until out_valid&&out_ready, then go to IDLE; in_ready rises the next cycle.
- Latency: out_valid rises exactly LAYERS*N*(N+1) cycles after the accept edge. For the defaults this is 12 cycles.
- Throughput: one vector per LAYERS*N*(N+1)+2 cycles when out_ready is held high.
- Arithmetic:
  - Products are 2*WIDTH signed.
  - The accumulator is 2*WIDTH+clog2(N) bits and never overflows.
  - The shift is arithmetic with truncation toward minus infinity.
  - Bias is added at full accumulator width.
  - Saturation to [-2^(WIDTH-1), 2^(WIDTH-1)-1] is applied only at BIAS.
  - ReLU is applied before saturation; a negative result becomes 0.
- Backpressure: out_ready=0 holds the engine in OUT with out_data frozen; in_ready stays 0.
- in_valid is ignored outside IDLE.

Decomposition:
- Package/include file seq_nn_pkg:
  - FSM state encodings;
  - ACT mode constants;
  - saturation limit constants;
  - the address-map formulas as constant functions.
- One sub-module, nn_mac_sat:
  - accumulator with clear/accumulate controls;
  - bias add, shift, activation and saturation;
  - parametrised by WIDTH, FRAC, N, ACT.

Test Plan:
1. Identity: load w=0x0100 on the diagonal, 0 elsewhere, biases 0. Apply in={0x0300,0xFE00} → out={0x0300,0xFE00}, with out_valid exactly 12 cycles after accept.
2. Saturation: all weights 0x0100, biases 0, in={0x7F00,0x7F00}, ACT=0 → out={0x7FFF,0x7FFF}. With in={0x8000,0x8000} → out={0x8000,0x8000}.
3. ReLU: ACT=1, identity weights, layer-0 bias={0xFF00,0}, in={0x0080,0x0200} → out={0x0000,0x0200}.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid. Required: out_data constant, in_ready=0, an in_valid pulse is ignored. Release → in_ready=1 on the next cycle.
5. Reset mid-op: drop rst_n at MAC cycle 4 → all outputs 0 within the same cycle. After release, busy=0, in_ready=1, and a read-back vector shows the coefficients cleared (output equals sat(0)=0).
6. Write while busy: cfg_we to address 0 with 0x0200 during MAC is dropped. The next vector's result uses the old coefficient.

Source files
------------

// File: rtl/seq_nn_pkg.sv
// Shared types and constants for the sequential fully-connected engine:
// FSM encoding, activation modes, saturation limits and the coefficient address map.
package seq_nn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_BIAS = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  localparam int ACT_IDENT = 0;
  localparam int ACT_RELU  = 1;

  function automatic longint sat_max(input int width);
    return (longint'(1) <<< (width - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int width);
    return -(longint'(1) <<< (width - 1));
  endfunction

  function automatic int coef_count(input int layers, input int n);
    return layers * n * (n + 1);
  endfunction

  // Weights occupy the low part of the map, biases follow all weights.
  function automatic int w_addr(input int n, input int l, input int j, input int i);
    return (l * n + j) * n + i;
  endfunction

  function automatic int b_addr(input int layers, input int n, input int l, input int j);
    return layers * n * n + l * n + j;
  endfunction

endpackage

// File: rtl/seq_neural_net_if.sv
// Streaming input/output handshakes plus coefficient write port of the engine.
interface seq_neural_net_if #(
  parameter int WIDTH  = 16,
  parameter int N      = 2,
  parameter int ADDR_W = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [N*WIDTH-1:0]   in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [N*WIDTH-1:0]   out_data;
  logic                 cfg_we;
  logic [ADDR_W-1:0]    cfg_addr;
  logic [WIDTH-1:0]     cfg_data;

  modport master (
    output in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_data,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_data,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/nn_mac_sat.sv
// Shared multiply-accumulate with a post-processing path: shift, bias add,
// optional ReLU and saturation back to WIDTH bits.
module nn_mac_sat
  import seq_nn_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int N     = 2,
  parameter int ACT   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    acc_en,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic signed [WIDTH-1:0] bias,
  output logic signed [WIDTH-1:0] result
);
  // Wide enough for N full-scale products, so the sum cannot wrap.
  localparam int ACC_W = 2 * WIDTH + $clog2(N);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_max(WIDTH));
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_min(WIDTH));

  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   acc_q, acc_d, sum, act_val;

  assign prod = a * b;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (acc_en) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_comb begin
    sum     = (acc_q >>> FRAC) + ACC_W'(bias);
    act_val = (ACT == ACT_RELU && sum < 0) ? '0 : sum;
    if (act_val > SAT_HI) begin
      result = SAT_HI[WIDTH-1:0];
    end else if (act_val < SAT_LO) begin
      result = SAT_LO[WIDTH-1:0];
    end else begin
      result = act_val[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/seq_neural_net.sv
// Time-multiplexed LAYERS x N fully-connected network: one product per cycle,
// one bias/activation cycle per neuron, results streamed out with valid/ready.
module seq_neural_net
  import seq_nn_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int FRAC   = 8,
  parameter int N      = 2,
  parameter int LAYERS = 2,
  parameter int ACT    = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_neural_net_if.slave bus,
  output logic            busy
);
  localparam int NCOEF  = coef_count(LAYERS, N);
  localparam int ADDR_W = $clog2(NCOEF);
  localparam int IW     = (N > 1) ? $clog2(N) : 1;
  localparam int LW     = (LAYERS > 1) ? $clog2(LAYERS) : 1;

  state_t                  state_q, state_d;
  logic [LW-1:0]           l_q, l_d;
  logic [IW-1:0]           j_q, j_d, i_q, i_d;
  logic signed [WIDTH-1:0] src_q  [N];
  logic signed [WIDTH-1:0] src_d  [N];
  logic signed [WIDTH-1:0] dest_q [N];
  logic signed [WIDTH-1:0] dest_d [N];
  logic signed [WIDTH-1:0] coef_q [NCOEF];
  logic signed [WIDTH-1:0] coef_d [NCOEF];
  logic [N*WIDTH-1:0]      out_data_q, out_data_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic                    busy_q, busy_d;
  logic                    mac_clr, mac_en;
  logic [ADDR_W-1:0]       w_idx, b_idx;
  logic signed [WIDTH-1:0] w_sel, bias_sel, src_sel, mac_res;

  assign w_idx    = ADDR_W'(w_addr(N, int'(l_q), int'(j_q), int'(i_q)));
  assign b_idx    = ADDR_W'(b_addr(LAYERS, N, int'(l_q), int'(j_q)));
  assign w_sel    = coef_q[w_idx];
  assign bias_sel = coef_q[b_idx];
  assign src_sel  = src_q[i_q];

  nn_mac_sat #(.WIDTH(WIDTH), .FRAC(FRAC), .N(N), .ACT(ACT)) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (mac_clr),
    .acc_en (mac_en),
    .a      (src_sel),
    .b      (w_sel),
    .bias   (bias_sel),
    .result (mac_res)
  );

  // Coefficients are only writable while idle so a running vector sees a stable set.
  always_comb begin
    coef_d = coef_q;
    if (bus.cfg_we && !busy_q && (int'(bus.cfg_addr) < NCOEF)) begin
      coef_d[bus.cfg_addr] = bus.cfg_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    l_d         = l_q;
    j_d         = j_q;
    i_d         = i_q;
    src_d       = src_q;
    dest_d      = dest_q;
    out_data_d  = out_data_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    mac_clr     = 1'b0;
    mac_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready_d = 1'b1;
        if (bus.in_valid && in_ready_q) begin
          for (int k = 0; k < N; k++) begin
            src_d[k] = bus.in_data[k*WIDTH +: WIDTH];
          end
          l_d        = '0;
          j_d        = '0;
          i_d        = '0;
          mac_clr    = 1'b1;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = ST_MAC;
        end
      end
      ST_MAC: begin
        mac_en = 1'b1;
        if (i_q == IW'(N - 1)) begin
          i_d     = '0;
          state_d = ST_BIAS;
        end else begin
          i_d = i_q + IW'(1);
        end
      end
      ST_BIAS: begin
        dest_d[j_q] = mac_res;
        mac_clr     = 1'b1;
        if (j_q != IW'(N - 1)) begin
          j_d     = j_q + IW'(1);
          state_d = ST_MAC;
        end else if (l_q != LW'(LAYERS - 1)) begin
          // Layer outputs become the next layer's sources.
          src_d   = dest_d;
          l_d     = l_q + LW'(1);
          j_d     = '0;
          state_d = ST_MAC;
        end else begin
          for (int k = 0; k < N; k++) begin
            out_data_d[k*WIDTH +: WIDTH] = dest_d[k];
          end
          out_valid_d = 1'b1;
          state_d     = ST_OUT;
        end
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      l_q         <= '0;
      j_q         <= '0;
      i_q         <= '0;
      src_q       <= '{default: '0};
      dest_q      <= '{default: '0};
      coef_q      <= '{default: '0};
      out_data_q  <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      l_q         <= l_d;
      j_q         <= j_d;
      i_q         <= i_d;
      src_q       <= src_d;
      dest_q      <= dest_d;
      coef_q      <= coef_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign busy          = busy_q;

endmodule
